// File: rtl/ram_io_responder_pkg.sv
// Shared constants and types for the byte-wide memory bus responder.
package ram_io_responder_pkg;

    localparam logic [1:0]  IO_REGION    = 2'b11;
    localparam logic [31:0] IO_TX_ADDR   = 32'h0003_0000;
    localparam logic [31:0] IO_STAT_ADDR = 32'h0003_0004;
    localparam int unsigned IO_DEC_W     = 18;
    localparam int unsigned BYTE_W       = 8;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic       ovf;
        logic       rx_full;
        logic       buf_full;
    } io_status_t;

    // Address bits above the IO decode width are ignored by the responder.
    function automatic logic io_hit(input logic [IO_DEC_W-1:0] a,
                                    input logic [IO_DEC_W-1:0] target);
        return a == target;
    endfunction

endpackage

// File: rtl/ram_io_responder_io_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the host transmit path.
module io_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_c,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic [$clog2(DEPTH):0]       count_next_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push.
    always_comb begin
        do_pop       = pop && !empty;
        do_push      = push && (!full || do_pop);
        count_next_c = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    assign head_c = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next_c;
            full  <= (count_next_c == CNT_W'(DEPTH));
            empty <= (count_next_c == '0);
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM plus memory-mapped IO window answering the core's memory controller.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_a,
    input  logic [BYTE_W-1:0] mem_dout,
    input  logic              mem_wr,
    output logic [BYTE_W-1:0] mem_din,
    output logic              io_buffer_full,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              sim_halt
);

    localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W     = $clog2(TX_DEPTH) + 1;

    logic [BYTE_W-1:0]     ram [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0] ram_idx;

    logic              is_io;
    logic              is_wr;
    logic              ram_wr;
    logic              tx_push;
    logic              halt_wr;
    logic              rx_rd;
    logic              stat_rd;
    logic              tx_drop;
    logic              rx_load;
    logic              rx_full;
    logic              rx_full_next;
    logic [BYTE_W-1:0] rx_byte;
    logic              ovf;
    io_status_t        status;
    logic [BYTE_W-1:0] io_rd_data;

    logic              tx_full;
    logic              tx_empty;
    logic [CNT_W-1:0]  unused_tx_count;
    logic [CNT_W-1:0]  tx_count_next;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^mem_a[31:IO_DEC_W];

    // Address decode and read-data selection for the IO window.
    always_comb begin
        is_io    = (mem_a[17:16] == IO_REGION);
        is_wr    = (mem_wr == MEM_WRITE);
        ram_idx  = mem_a[ADDR_WIDTH-1:0];
        ram_wr   = !rst && is_wr && !is_io;
        tx_push  = !rst && is_wr && is_io && io_hit(mem_a[IO_DEC_W-1:0], IO_TX_ADDR[IO_DEC_W-1:0]);
        halt_wr  = is_wr && is_io && io_hit(mem_a[IO_DEC_W-1:0], IO_STAT_ADDR[IO_DEC_W-1:0]);
        rx_rd    = !is_wr && is_io && io_hit(mem_a[IO_DEC_W-1:0], IO_TX_ADDR[IO_DEC_W-1:0]);
        stat_rd  = !is_wr && is_io && io_hit(mem_a[IO_DEC_W-1:0], IO_STAT_ADDR[IO_DEC_W-1:0]);
        tx_drop  = tx_push && tx_full && !(tx_valid && tx_ready);

        rx_load      = rx_valid && rx_ready;
        rx_full_next = rx_load || (rx_full && !rx_rd);

        status          = '0;
        status.ovf      = ovf;
        status.rx_full  = rx_full;
        status.buf_full = io_buffer_full;

        io_rd_data = '0;
        if (rx_rd && rx_full) begin
            io_rd_data = rx_byte;
        end else if (stat_rd) begin
            io_rd_data = status;
        end
    end

    // RAM array carries no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din        <= '0;
            rx_full        <= 1'b0;
            rx_byte        <= '0;
            rx_ready       <= 1'b0;
            ovf            <= 1'b0;
            sim_halt       <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            if (!is_wr) begin
                mem_din <= is_io ? io_rd_data : ram[ram_idx];
            end
            if (rx_load) begin
                rx_byte <= rx_data;
            end
            rx_full  <= rx_full_next;
            rx_ready <= !rx_full_next;
            if (tx_drop) begin
                ovf <= 1'b1;
            end
            if (halt_wr) begin
                sim_halt <= 1'b1;
            end
            // Two-entry margin absorbs a write issued against a stale flag.
            io_buffer_full <= (tx_count_next >= CNT_W'(TX_DEPTH - 2));
        end
    end

    io_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (BYTE_W)
    ) u_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (tx_push),
        .push_data    (mem_dout),
        .pop          (tx_ready),
        .head_c       (tx_data),
        .full         (tx_full),
        .empty        (tx_empty),
        .count        (unused_tx_count),
        .count_next_c (tx_count_next)
    );

    assign tx_valid = !tx_empty;

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: driver queues expectations, monitor checks them.
module tb_ram_io_responder;

    typedef enum int {SIG_DIN, SIG_IOFULL, SIG_TXVALID, SIG_TXDATA, SIG_RXRDY, SIG_HALT} sig_e;

    typedef struct {
        int         due;
        sig_e       sig;
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        sim_halt;

    exp_t       exp_q[$];
    logic [7:0] tx_exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] mon_act;
    logic [7:0] mon_exp;

    ram_io_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .sim_halt       (sim_halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sample(input sig_e s);
        case (s)
            SIG_DIN:     return mem_din;
            SIG_IOFULL:  return {7'b0, io_buffer_full};
            SIG_TXVALID: return {7'b0, tx_valid};
            SIG_TXDATA:  return tx_data;
            SIG_RXRDY:   return {7'b0, rx_ready};
            default:     return {7'b0, sim_halt};
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle and every TX handshake.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due <= cyc) begin
                mon_act = sample(exp_q[i].sig);
                tests++;
                if (exp_q[i].due < cyc || mon_act !== exp_q[i].exp) begin
                    fails++;
                    $display("FAIL %s: got %02h expected %02h (due %0d, cycle %0d)",
                             exp_q[i].name, mon_act, exp_q[i].exp, exp_q[i].due, cyc);
                end
                exp_q.delete(i);
            end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            tests++;
            if (tx_exp_q.size() == 0) begin
                fails++;
                $display("FAIL tx_pop: got %02h expected no byte pending", tx_data);
            end else begin
                mon_exp = tx_exp_q.pop_front();
                if (tx_data !== mon_exp) begin
                    fails++;
                    $display("FAIL tx_pop: got %02h expected %02h", tx_data, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int due, input sig_e s, input logic [7:0] v, input string n);
        exp_t e;
        e.due  = due;
        e.sig  = s;
        e.exp  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic expect_now(input sig_e s, input logic [7:0] v, input string n);
        expect_at(cyc, s, v, n);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        mem_a    = a;
        mem_dout = d;
        mem_wr   = 1'b1;
        step();
        mem_wr   = 1'b0;
        mem_a    = 32'h0;
    endtask

    task automatic wr_tx(input logic [7:0] d, input bit accepted);
        if (accepted) tx_exp_q.push_back(d);
        wr(32'h0003_0000, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] e, input string n);
        mem_a  = a;
        mem_wr = 1'b0;
        expect_at(cyc + 1, SIG_DIN, e, n);
        step();
        mem_a  = 32'h0;
    endtask

    task automatic check_int(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        mem_a    = 32'h0;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;

        // Reset state
        repeat (3) step();
        expect_now(SIG_DIN,     8'h00, "rst_mem_din");
        expect_now(SIG_IOFULL,  8'h00, "rst_io_buffer_full");
        expect_now(SIG_TXVALID, 8'h00, "rst_tx_valid");
        expect_now(SIG_TXDATA,  8'h00, "rst_tx_data");
        expect_now(SIG_HALT,    8'h00, "rst_sim_halt");
        rst = 1'b0;
        step();
        expect_now(SIG_RXRDY, 8'h01, "rst_rx_ready_after_clock");

        // RAM write high byte first, then sequential reads
        wr(32'h103, 8'h78);
        wr(32'h102, 8'h56);
        wr(32'h101, 8'h34);
        wr(32'h100, 8'h12);
        rd(32'h100, 8'h12, "ram_rd_100");
        rd(32'h101, 8'h34, "ram_rd_101");
        rd(32'h102, 8'h56, "ram_rd_102");
        rd(32'h103, 8'h78, "ram_rd_103");
        rd(32'hFF00_0100, 8'h12, "ram_rd_upper_bits_ignored");

        // Write-then-read hazard
        wr(32'h200, 8'hAB);
        rd(32'h200, 8'hAB, "ram_wr_rd_hazard");

        // TX flow control
        repeat (5) wr_tx(8'h41, 1'b1);
        expect_now(SIG_IOFULL, 8'h00, "tx_full_after_5");
        wr_tx(8'h41, 1'b1);
        expect_now(SIG_IOFULL,  8'h01, "tx_full_after_6");
        expect_now(SIG_TXVALID, 8'h01, "tx_valid_after_6");
        tx_ready = 1'b1;
        step();
        expect_now(SIG_IOFULL, 8'h00, "tx_full_falls_at_5");
        repeat (5) step();
        expect_now(SIG_TXVALID, 8'h00, "tx_valid_after_drain");
        tx_ready = 1'b0;
        check_int("tx_drain_all_seen", tx_exp_q.size(), 0);

        // RX path
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        expect_now(SIG_RXRDY, 8'h00, "rx_ready_after_load");
        rd(32'h0003_0004, 8'h02, "rx_status");
        rd(32'h0003_0000, 8'h5A, "rx_read_byte");
        expect_now(SIG_RXRDY, 8'h01, "rx_ready_after_read");
        rd(32'h0003_0000, 8'h00, "rx_read_empty");

        // Overflow: ninth push is dropped
        for (int i = 0; i < 9; i++) wr_tx(8'(8'h60 + i), i < 8);
        expect_now(SIG_IOFULL,  8'h01, "ovf_io_buffer_full");
        expect_now(SIG_TXVALID, 8'h01, "ovf_tx_valid");
        rd(32'h0003_0004, 8'h05, "ovf_status");
        tx_ready = 1'b1;
        repeat (7) step();
        expect_now(SIG_TXVALID, 8'h01, "ovf_one_left");
        step();
        expect_now(SIG_TXVALID, 8'h00, "ovf_drained_eight");
        tx_ready = 1'b0;
        check_int("ovf_drain_all_seen", tx_exp_q.size(), 0);

        // Halt and ignored IO offsets
        wr(32'hABC3_0004, 8'h00);
        expect_now(SIG_HALT, 8'h01, "sim_halt_set");
        wr(32'h0003_0008, 8'h55);
        expect_now(SIG_TXVALID, 8'h00, "io_other_wr_ignored");
        rd(32'h0003_0008, 8'h00, "io_other_rd_zero");

        // Reset in the middle of a drain, with a RAM write on the rst cycle
        for (int i = 0; i < 7; i++) wr_tx(8'(8'h71 + i), 1'b1);
        tx_ready = 1'b1;
        step();
        expect_now(SIG_IOFULL,  8'h01, "pre_rst_io_buffer_full");
        expect_now(SIG_TXVALID, 8'h01, "pre_rst_tx_valid");
        rst      = 1'b1;
        mem_a    = 32'h103;
        mem_dout = 8'hEE;
        mem_wr   = 1'b1;
        step();
        rst      = 1'b0;
        mem_wr   = 1'b0;
        mem_a    = 32'h0;
        tx_exp_q.delete();
        expect_now(SIG_HALT,    8'h00, "mid_rst_sim_halt");
        expect_now(SIG_TXVALID, 8'h00, "mid_rst_tx_valid");
        expect_now(SIG_IOFULL,  8'h00, "mid_rst_io_buffer_full");
        expect_now(SIG_DIN,     8'h00, "mid_rst_mem_din");
        expect_now(SIG_TXDATA,  8'h00, "mid_rst_tx_data");
        tx_ready = 1'b0;
        rd(32'h103, 8'h78, "ram_kept_103_no_rst_write");
        expect_now(SIG_RXRDY, 8'h01, "mid_rst_rx_ready");
        rd(32'h100, 8'h12, "ram_kept_100");

        repeat (2) step();
        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
